fsm_counter_ctrl: RTL and testbench

Sequencing controller for the free-running modulo-2^WIDTH state counter used in the FSM exercises. It owns the count register and advances it under command control (continuous run, single step, N-step burst, stop/clear), so a test harness or upstream FSM can drive the counter through a valid/ready command port instead of a raw clock enable. It sits between the command source and any logic consuming the count/state value.

---
 rtl/fsm_counter_ctrl_if.sv | 26 ++
 rtl/fsm_counter_ctrl.sv | 120 ++++++++++++
 tb/tb_fsm_counter_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_counter_ctrl_if.sv
// Command/status bundle for fsm_counter_ctrl: a valid/ready command port plus
// the count and status outputs seen by the consumer.
interface fsm_counter_ctrl_if #(
    parameter int WIDTH   = 2,
    parameter int BURST_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [BURST_W-1:0] cmd_arg;
    logic               cnt_en;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_arg,
        input  cmd_ready, cnt_en, count, busy, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg,
        output cmd_ready, cnt_en, count, busy, done, wrap
    );
endinterface

// File: rtl/fsm_counter_ctrl.sv
// Command-driven sequencer for a modulo-2^WIDTH counter (run, step, N-step burst, stop/clear).
// Optional macro FSM_CTRL_WRAP_EN enables the registered wrap pulse; otherwise wrap is tied to 0.
module fsm_counter_ctrl #(
    parameter int WIDTH   = 2,
    parameter int BURST_W = 8
) (
    input logic               clk,
    input logic               rst,
    fsm_counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_BURST = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               cnt_en;
    logic               cmd_ready;
    logic               accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        cnt_en      = 1'b0;
        cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN);
        accept      = bus.cmd_valid && cmd_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_STOP:  count_d = '0;
                        OP_RUN:   state_d = ST_RUN;
                        OP_STEP:  cnt_en  = 1'b1;
                        OP_BURST: begin
                            if (bus.cmd_arg != '0) begin
                                remaining_d = bus.cmd_arg;
                                state_d     = ST_BURST;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            // Non-STOP commands are consumed while running so the source never stalls.
            ST_RUN: begin
                cnt_en = 1'b1;
                if (accept && (bus.cmd_op == OP_STOP)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                cnt_en      = 1'b1;
                remaining_d = remaining_q - BURST_W'(1);
                if (remaining_q == BURST_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (cnt_en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.cnt_en    = cnt_en;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

`ifdef FSM_CTRL_WRAP_EN
    logic wrap_q, wrap_d;

    // Only a real increment out of the top value counts; a STOP clear never does.
    always_comb begin
        wrap_d = cnt_en && (count_q == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.wrap = wrap_q;
`else
    assign bus.wrap = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// Scoreboard bench for fsm_counter_ctrl: directed test-plan sequences followed by
// random commands, checked against a command-level model of the counter.
module tb_fsm_counter_ctrl;

   localparam int WIDTH   = 2;
   localparam int BURST_W = 8;
   localparam int MODV    = 4;

   localparam logic [1:0] OP_STOP  = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_STEP  = 2'b10;
   localparam logic [1:0] OP_BURST = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fsm_counter_ctrl_if #(.WIDTH(WIDTH), .BURST_W(BURST_W)) bus ();

   fsm_counter_ctrl #(.WIDTH(WIDTH), .BURST_W(BURST_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int count;
      int busy;
   } accExp_t;

   typedef struct {
      int count;
      int busyLen;
   } doneExp_t;

   accExp_t  accQ[$];
   doneExp_t doneQ[$];

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int accCount = 0;
   int accHandled = 0;

   int modelCount = 0;
   bit modelRun = 1'b0;
   int runBase = 0;
   int runEdge = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Edge counter and acceptance detector, sampled with pre-edge values.
   always @(posedge clk) begin
      cycle++;
      if (!rst && bus.cmd_valid && bus.cmd_ready) accCount++;
   end

   // Monitor: pops expectations whenever the DUT accepts a command or pulses done.
   int  busyRun = 0;
   int  prevCount = 0;
   int  prevEn = 0;
   bit  prevValid = 1'b0;
   always @(negedge clk) begin
      accExp_t  ea;
      doneExp_t ed;
      int       expWrap;
      if (rst) begin
         busyRun    = 0;
         prevValid  = 1'b0;
         accHandled = accCount;
      end else begin
         while (accHandled < accCount) begin
            accHandled++;
            if (accQ.size() == 0) begin
               checkOutput("unexpected_accept", 1, 0);
            end else begin
               ea = accQ.pop_front();
               checkOutput("count_after_accept", int'(bus.count), ea.count);
               checkOutput("busy_after_accept", int'(bus.busy), ea.busy);
            end
         end
         if (bus.busy) busyRun++;
         if (bus.done) begin
            if (doneQ.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               ed = doneQ.pop_front();
               checkOutput("count_at_done", int'(bus.count), ed.count);
               checkOutput("busy_cycles_at_done", busyRun, ed.busyLen);
            end
            checkOutput("ready_in_done", int'(bus.cmd_ready), 0);
            checkOutput("cnt_en_in_done", int'(bus.cnt_en), 0);
         end
         if (!bus.busy) begin
            checkOutput("ready_when_idle", int'(bus.cmd_ready), 1);
            busyRun = 0;
         end
`ifdef FSM_CTRL_WRAP_EN
         expWrap = (prevValid && prevEn == 1 && prevCount == MODV - 1 && int'(bus.count) == 0) ? 1 : 0;
`else
         expWrap = 0;
`endif
         checkOutput("wrap", int'(bus.wrap), expWrap);
         prevCount = int'(bus.count);
         prevEn    = int'(bus.cnt_en);
         prevValid = 1'b1;
      end
   end

   // Drives one command and holds it until accepted; returns the accept edge number.
   task automatic applyStimulus(input logic [1:0] op, input int arg, output int k);
      int   budget;
      logic rdy;
      bit   finished;
      k = -1;
      budget = 0;
      finished = 1'b0;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_arg   = BURST_W'(arg);
      while (!finished) begin
         @(negedge clk);
         rdy = bus.cmd_ready;
         k = cycle + 1;
         @(posedge clk);
         if (rdy) begin
            finished = 1'b1;
         end else begin
            budget++;
            if (budget > 60) begin
               k = -1;
               finished = 1'b1;
            end
         end
      end
      #1;
      bus.cmd_valid = 1'b0;
      if (k < 0) checkOutput("accept_timeout", 0, 1);
   endtask

   // Issues a command and records what the model says must follow.
   task automatic issue(input logic [1:0] op, input int arg);
      int k;
      int c;
      applyStimulus(op, arg, k);
      if (k >= 0) begin
         if (modelRun) begin
            c = (runBase + (k - runEdge)) % MODV;
            if (op == OP_STOP) begin
               modelCount = c;
               modelRun = 1'b0;
               accQ.push_back('{count: c, busy: 0});
            end else begin
               accQ.push_back('{count: c, busy: 1});
            end
         end else begin
            case (op)
               OP_STOP: begin
                  modelCount = 0;
                  accQ.push_back('{count: 0, busy: 0});
               end
               OP_RUN: begin
                  accQ.push_back('{count: modelCount, busy: 1});
                  modelRun = 1'b1;
                  runBase = modelCount;
                  runEdge = k;
               end
               OP_STEP: begin
                  modelCount = (modelCount + 1) % MODV;
                  accQ.push_back('{count: modelCount, busy: 0});
               end
               default: begin
                  accQ.push_back('{count: modelCount, busy: 1});
                  modelCount = (modelCount + arg) % MODV;
                  doneQ.push_back('{count: modelCount, busyLen: arg + 1});
               end
            endcase
         end
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_count"}, int'(bus.count), 0);
      checkOutput({tag, "_busy"}, int'(bus.busy), 0);
      checkOutput({tag, "_done"}, int'(bus.done), 0);
      checkOutput({tag, "_wrap"}, int'(bus.wrap), 0);
      checkOutput({tag, "_cnt_en"}, int'(bus.cnt_en), 0);
      checkOutput({tag, "_ready"}, int'(bus.cmd_ready), 1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_STOP;
      bus.cmd_arg   = '0;
      rst = 1'b1;
      #1;
      checkResetState("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] directed: steps");
      repeat (5) issue(OP_STEP, 0);

      $display("[TB] directed: bursts");
      issue(OP_STOP, 0);
      issue(OP_BURST, 6);
      issue(OP_BURST, 0);

      $display("[TB] directed: run/stop");
      issue(OP_STOP, 0);
      issue(OP_RUN, 0);
      repeat (8) @(posedge clk);
      issue(OP_STOP, 0);
      repeat (3) @(posedge clk);
      issue(OP_STOP, 0);

      $display("[TB] directed: commands while running");
      issue(OP_RUN, 0);
      issue(OP_STEP, 0);
      issue(OP_BURST, 5);
      issue(OP_RUN, 0);
      issue(OP_STOP, 0);

      $display("[TB] directed: held command during burst");
      issue(OP_BURST, 8);
      issue(OP_STEP, 0);

      $display("[TB] directed: reset mid-burst");
      issue(OP_BURST, 8);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkResetState("midburst_reset");
      doneQ.delete();
      modelCount = 0;
      modelRun = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] random commands");
      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         issue(op, int'($urandom_range(0, 9)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      if (modelRun) issue(OP_STOP, 0);

      repeat (20) @(posedge clk);
      checkOutput("acc_queue_drained", accQ.size(), 0);
      checkOutput("done_queue_drained", doneQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
